// File: rtl/lzs_dec_sched.sv
// lzs_dec_sched: time-shares one LZS decode engine between NCH job requesters.
// Round-robin pick, engine clear, start strobe, then supervision of the run
// (byte count, overflow, stall timeout, abort) and a one-cycle completion report.
module lzs_dec_sched #(
    parameter int NCH     = 4,
    parameter int CW      = 2,
    parameter int LW      = 16,
    parameter int TMO_CYC = 4096,
    parameter int CLR_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [LW*NCH-1:0] max_len,
    input  logic [NCH-1:0]    abort,
    output logic [NCH-1:0]    grant,
    output logic              eng_clr,
    output logic              eng_ce,
    input  logic              eng_out_valid,
    input  logic              eng_out_done,
    input  logic              fo_full,
    output logic              done_pulse,
    output logic [CW-1:0]     done_ch,
    output logic [1:0]        done_status,
    output logic [LW-1:0]     done_bytes,
    output logic              busy
);

    localparam int TW  = $clog2(TMO_CYC);
    localparam int CCW = $clog2(CLR_CYC + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_OVERFLOW = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_CLR,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NCH-1:0]    grant_q, grant_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     last_q, last_d;
    logic [LW-1:0]     max_len_q, max_len_d;
    logic [LW-1:0]     bytes_q, bytes_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [CCW-1:0]    clr_cnt_q, clr_cnt_d;
    logic              eng_clr_q, eng_clr_d;
    logic              eng_ce_q, eng_ce_d;
    logic              done_pulse_q, done_pulse_d;
    logic [CW-1:0]     done_ch_q, done_ch_d;
    logic [1:0]        done_status_q, done_status_d;
    logic [LW-1:0]     done_bytes_q, done_bytes_d;
    logic              busy_q, busy_d;

    logic              arb_found;
    logic [CW-1:0]     arb_pick;
    logic              abort_hit;
    logic              ovf_hit;
    logic              tmo_hit;
    logic              run_end;

    // Round-robin search: first requester after the last-served one, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!arb_found && req[(int'(last_q) + i) % NCH]) begin
                arb_found = 1'b1;
                arb_pick  = CW'((int'(last_q) + i) % NCH);
            end
        end
    end

    // A byte arriving when the count already equals the limit is the overflow
    // byte. Timeout looks at the idle count this cycle will produce, so a stall
    // (fo_full) in the deciding cycle still prevents it.
    assign abort_hit = abort[idx_q];
    assign ovf_hit   = eng_out_valid && (bytes_q == max_len_q);
    assign tmo_hit   = !eng_out_valid && !fo_full && (idle_q == TW'(TMO_CYC - 2));
    assign run_end   = abort_hit || ovf_hit || eng_out_done || tmo_hit;

    // State register plus control/output flops; everything clears on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_q        <= CW'(NCH - 1);
            eng_clr_q     <= 1'b0;
            eng_ce_q      <= 1'b0;
            done_pulse_q  <= 1'b0;
            done_ch_q     <= '0;
            done_status_q <= '0;
            done_bytes_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            eng_clr_q     <= eng_clr_d;
            eng_ce_q      <= eng_ce_d;
            done_pulse_q  <= done_pulse_d;
            done_ch_q     <= done_ch_d;
            done_status_q <= done_status_d;
            done_bytes_q  <= done_bytes_d;
            busy_q        <= busy_d;
        end
    end

    // Per-job working registers; always reloaded in ARB before use.
    always_ff @(posedge clk) begin
        idx_q     <= idx_d;
        max_len_q <= max_len_d;
        bytes_q   <= bytes_d;
        idle_q    <= idle_d;
        clr_cnt_q <= clr_cnt_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_ARB;
            S_ARB:   state_d = arb_found ? S_CLR : S_IDLE;
            S_CLR:   if (clr_cnt_q == CCW'(CLR_CYC - 1)) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (run_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; outputs are registered from the state being entered.
    always_comb begin
        grant_d       = grant_q;
        idx_d         = idx_q;
        last_d        = last_q;
        max_len_d     = max_len_q;
        bytes_d       = bytes_q;
        idle_d        = idle_q;
        clr_cnt_d     = clr_cnt_q;
        done_ch_d     = done_ch_q;
        done_status_d = done_status_q;
        done_bytes_d  = done_bytes_q;
        eng_clr_d     = (state_d == S_CLR);
        eng_ce_d      = (state_d == S_START);
        done_pulse_d  = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE);

        case (state_q)
            S_ARB: begin
                grant_d   = arb_found ? (NCH'(1) << arb_pick) : '0;
                idx_d     = arb_pick;
                max_len_d = max_len[int'(arb_pick) * LW +: LW];
                bytes_d   = '0;
                idle_d    = '0;
                clr_cnt_d = '0;
            end
            S_CLR: begin
                clr_cnt_d = clr_cnt_q + CCW'(1);
            end
            S_RUN: begin
                if (eng_out_valid && (bytes_q != max_len_q)) begin
                    bytes_d = bytes_q + LW'(1);
                end
                idle_d = (eng_out_valid || fo_full) ? '0 : idle_q + TW'(1);
                if (run_end) begin
                    done_ch_d = idx_q;
                    if (abort_hit) begin
                        done_status_d = ST_ABORT;
                        done_bytes_d  = bytes_q;
                    end else if (ovf_hit) begin
                        done_status_d = ST_OVERFLOW;
                        done_bytes_d  = bytes_q;
                    end else if (eng_out_done) begin
                        done_status_d = ST_OK;
                        done_bytes_d  = bytes_d;
                    end else begin
                        done_status_d = ST_TIMEOUT;
                        done_bytes_d  = bytes_q;
                    end
                end
            end
            S_DONE: begin
                grant_d = '0;
                last_d  = idx_q;
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign eng_clr     = eng_clr_q;
    assign eng_ce      = eng_ce_q;
    assign done_pulse  = done_pulse_q;
    assign done_ch     = done_ch_q;
    assign done_status = done_status_q;
    assign done_bytes  = done_bytes_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lzs_dec_sched.sv
// tb_lzs_dec_sched: directed bench for the LZS engine scheduler.
module tb_lzs_dec_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int LW  = 16;
    localparam int TMO = 16;
    localparam int CLR = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [LW*NCH-1:0] max_len;
    logic [NCH-1:0]    abort;
    logic [NCH-1:0]    grant;
    logic              eng_clr;
    logic              eng_ce;
    logic              eng_out_valid;
    logic              eng_out_done;
    logic              fo_full;
    logic              done_pulse;
    logic [CW-1:0]     done_ch;
    logic [1:0]        done_status;
    logic [LW-1:0]     done_bytes;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int ce_cnt   = 0;
    int clr_cnt  = 0;

    lzs_dec_sched #(
        .NCH(NCH), .CW(CW), .LW(LW), .TMO_CYC(TMO), .CLR_CYC(CLR)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .max_len(max_len), .abort(abort),
        .grant(grant), .eng_clr(eng_clr), .eng_ce(eng_ce),
        .eng_out_valid(eng_out_valid), .eng_out_done(eng_out_done),
        .fo_full(fo_full), .done_pulse(done_pulse), .done_ch(done_ch),
        .done_status(done_status), .done_bytes(done_bytes), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobe cycles on the inactive edge.
    always @(negedge clk) begin
        if (eng_ce)  ce_cnt++;
        if (eng_clr) clr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        abort = '0;
        eng_out_valid = 1'b0;
        eng_out_done = 1'b0;
        fo_full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ce(input string tag);
        int n = 0;
        while (!eng_ce && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(eng_ce), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!done_pulse && n < 40);
        check(tag, 32'(done_pulse), 32'd1);
    endtask

    task automatic feed(input int n);
        eng_out_valid = 1'b1;
        repeat (n) tick();
        eng_out_valid = 1'b0;
    endtask

    initial begin
        int c0_ce;
        int c0_clr;
        int dp;
        max_len = '0;
        for (int k = 0; k < NCH; k++) max_len[k*LW +: LW] = 16'd100;

        // Reset values
        rst = 1'b1;
        req = '0; abort = '0; eng_out_valid = 1'b0; eng_out_done = 1'b0; fo_full = 1'b0;
        tick();
        tick();
        check("rst_ctrl", 32'({grant, eng_clr, eng_ce, done_pulse, done_ch, done_status, busy}), 32'd0);
        check("rst_bytes", 32'(done_bytes), 32'd0);
        rst = 1'b0;

        // Request vanishes while in ARB: back to idle, no grant
        req = 4'b0001;
        tick();
        check("arbdrop_busy_in_arb", 32'(busy), 32'd1);
        req = '0;
        tick();
        check("arbdrop_grant", 32'(grant), 32'd0);
        check("arbdrop_clr", 32'(eng_clr), 32'd0);
        check("arbdrop_busy", 32'(busy), 32'd0);

        // Test 1: single channel, 5 bytes then done
        do_reset();
        c0_ce = ce_cnt;
        c0_clr = clr_cnt;
        req = 4'b0001;
        wait_ce("t1_ce");
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_clr_cycles", 32'(clr_cnt - c0_clr), 32'd2);
        tick();
        check("t1_ce_low_run", 32'(eng_ce), 32'd0);
        feed(5);
        eng_out_done = 1'b1;
        wait_done("t1_done");
        eng_out_done = 1'b0;
        req = '0;
        check("t1_ch", 32'(done_ch), 32'd0);
        check("t1_status", 32'(done_status), 32'd0);
        check("t1_bytes", 32'(done_bytes), 32'd5);
        check("t1_grant_in_done", 32'(grant), 32'h1);
        check("t1_ce_cycles", 32'(ce_cnt - c0_ce), 32'd1);
        tick();
        check("t1_pulse_1cyc", 32'(done_pulse), 32'd0);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_bytes_hold", 32'(done_bytes), 32'd5);

        // Test 2: all channels held, round-robin order 0,1,2,3,0
        do_reset();
        c0_ce = ce_cnt;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ce("t2_ce");
            check("t2_grant", 32'(grant), 32'(1 << (j % 4)));
            tick();
            feed(2);
            eng_out_done = 1'b1;
            wait_done("t2_done");
            eng_out_done = 1'b0;
            if (j == 4) req = '0;
            check("t2_ch", 32'(done_ch), 32'(j % 4));
            check("t2_status", 32'(done_status), 32'd0);
            check("t2_bytes", 32'(done_bytes), 32'd2);
        end
        tick();
        tick();
        check("t2_ce_count", 32'(ce_cnt - c0_ce), 32'd5);
        check("t2_idle", 32'(busy), 32'd0);

        // Test 3: max_len 3 on ch1, fourth byte overflows
        do_reset();
        max_len[1*LW +: LW] = 16'd3;
        req = 4'b0010;
        wait_ce("t3_ce");
        check("t3_grant", 32'(grant), 32'h2);
        tick();
        eng_out_valid = 1'b1;
        repeat (3) tick();
        check("t3_no_done_yet", 32'(done_pulse), 32'd0);
        tick();
        eng_out_valid = 1'b0;
        req = '0;
        check("t3_done", 32'(done_pulse), 32'd1);
        check("t3_status", 32'(done_status), 32'd1);
        check("t3_bytes", 32'(done_bytes), 32'd3);
        check("t3_ch", 32'(done_ch), 32'd1);
        tick();

        // max_len 0: first byte overflows with zero bytes
        max_len[1*LW +: LW] = 16'd0;
        req = 4'b0010;
        wait_ce("t3z_ce");
        tick();
        eng_out_valid = 1'b1;
        tick();
        eng_out_valid = 1'b0;
        req = '0;
        check("t3z_done", 32'(done_pulse), 32'd1);
        check("t3z_status", 32'(done_status), 32'd1);
        check("t3z_bytes", 32'(done_bytes), 32'd0);
        tick();
        max_len[1*LW +: LW] = 16'd100;

        // Test 4: timeout 15 cycles after RUN entry; fo_full stall prevents it
        do_reset();
        req = 4'b0001;
        wait_ce("t4_ce");
        repeat (15) tick();
        check("t4_not_yet", 32'(done_pulse), 32'd0);
        tick();
        req = '0;
        check("t4_done", 32'(done_pulse), 32'd1);
        check("t4_status", 32'(done_status), 32'd2);
        check("t4_bytes", 32'(done_bytes), 32'd0);
        tick();
        req = 4'b0001;
        fo_full = 1'b1;
        wait_ce("t4s_ce");
        dp = 0;
        repeat (40) begin
            tick();
            if (done_pulse) dp++;
        end
        check("t4s_no_timeout", 32'(dp), 32'd0);
        check("t4s_busy", 32'(busy), 32'd1);
        fo_full = 1'b0;
        eng_out_done = 1'b1;
        wait_done("t4s_done");
        eng_out_done = 1'b0;
        req = '0;
        check("t4s_status", 32'(done_status), 32'd0);
        tick();

        // Test 5: abort for other channel ignored; own abort beats out_done
        do_reset();
        req = 4'b0100;
        wait_ce("t5_ce");
        check("t5_grant", 32'(grant), 32'h4);
        tick();
        abort = 4'b0001;
        feed(3);
        check("t5_abort0_ignored", 32'(done_pulse), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        abort = 4'b0100;
        eng_out_done = 1'b1;
        tick();
        abort = '0;
        eng_out_done = 1'b0;
        req = '0;
        check("t5_done", 32'(done_pulse), 32'd1);
        check("t5_status", 32'(done_status), 32'd3);
        check("t5_bytes", 32'(done_bytes), 32'd3);
        check("t5_ch", 32'(done_ch), 32'd2);
        tick();

        // Test 6: reset during RUN, then a clean ch2 job
        do_reset();
        req = 4'b0001;
        wait_ce("t6_ce");
        tick();
        feed(2);
        check("t6_running", 32'({grant, busy}), 32'b00011);
        rst = 1'b1;
        req = '0;
        #1;
        check("t6_async_clear", 32'({grant, eng_clr, eng_ce, done_pulse, busy}), 32'd0);
        tick();
        check("t6_clear_edge", 32'({grant, eng_clr, eng_ce, done_pulse, done_ch, done_status, busy}), 32'd0);
        check("t6_clear_bytes", 32'(done_bytes), 32'd0);
        rst = 1'b0;
        req = 4'b0100;
        wait_ce("t6b_ce");
        check("t6b_grant", 32'(grant), 32'h4);
        tick();
        feed(1);
        eng_out_done = 1'b1;
        wait_done("t6b_done");
        eng_out_done = 1'b0;
        req = '0;
        check("t6b_ch", 32'(done_ch), 32'd2);
        check("t6b_status", 32'(done_status), 32'd0);
        check("t6b_bytes", 32'(done_bytes), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
